uart_rx_os: RTL
===============

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload width, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning 1 or 2 stop bits checked.
REQ-006 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port rx_en  input  1  receive enable.
REQ-009 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port data_out  output  DATA_BITS  received word, LSB received first.
REQ-011 SHALL have port data_valid  output  1  data_out, frame_err and parity_err valid.
REQ-012 SHALL have port data_ready  input  1  consumer accepts word when data_valid high.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port frame_err  output  1  at least one checked stop bit sampled low.
REQ-015 SHALL have port parity_err  output  1  parity mismatch; 0 when PARITY=0.
REQ-016 SHALL have port overrun_err  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value.
REQ-018 SHALL generate a 16x oversample tick every DIV=CLK_FREQ/(BAUD*16) clocks (integer truncation); the divider restarts at 0 on start-edge detection.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE->START on a synchronized 1->0 transition while rx_en=1; busy=1 in every state except IDLE.
REQ-021 SHALL sample each bit once, on oversample count 7 of 0..15 (mid-bit).
REQ-022 START: mid-sample high -> false start, return to IDLE, nothing reported; low -> DATA.
REQ-023 DATA: shift DATA_BITS samples LSB first, then go to PARITY if PARITY!=0, else STOP.
REQ-024 PARITY: compare sample against XOR of data (even) or its inverse (odd); mismatch sets the word's parity_err.
REQ-025 STOP: sample STOP_BITS stop bits; any low sets the word's frame_err; after the last stop mid-sample return to IDLE immediately, so a start edge in the remaining half bit is accepted.
REQ-026 On completion, the clock after the last stop mid-sample: load data_out, frame_err, parity_err and set data_valid.
REQ-027 Word with errors SHALL still be delivered with its flags set.
REQ-028 data_valid, data_out and flags SHALL hold until a cycle with data_valid and data_ready both high; data_valid then clears the next clock.
REQ-029 If a word completes while data_valid=1 and data_ready=0, the new word is discarded, the held word is unchanged, and overrun_err pulses for one cycle.
REQ-030 If completion and acceptance occur in the same cycle, the new word SHALL load and data_valid SHALL stay high without overrun.
REQ-031 rx_en=0 SHALL abort any frame to IDLE within one clock with nothing reported; a held output word and data_valid are retained.

Reset
REQ-032 With rst_n=0 at a clock edge: state IDLE, divider and counters 0, synchronizer 1, data_out 0, and data_valid, busy, frame_err, parity_err, overrun_err all 0.
REQ-033 Reset mid-frame SHALL discard the partial word and any held word.

Structure
REQ-034 Package uart_pkg SHALL hold the state enumeration, the parity encoding constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the oversample ratio constant 16.
REQ-035 The oversample tick divider SHALL be the sub-module uart_os_tick (params CLK_FREQ, BAUD; ports clk, rst_n, clear, tick).

Verification
REQ-036 Defaults (DIV=27), data_ready=1, send 0xA5 with 1 stop bit -> data_valid one cycle, data_out=0xA5, frame_err=0, parity_err=0.
REQ-037 PARITY=2, send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-038 STOP_BITS=2, send 0x5A with the second stop bit low -> data_out=0x5A, frame_err=1.
REQ-039 rx low pulse of 4 bit-periods/16 (glitch) -> false start, no data_valid, busy back to 0.
REQ-040 data_ready=0, send 0x11 then 0x22 -> data_out holds 0x11 and overrun_err pulses once; raising data_ready then clears data_valid.
REQ-041 Drop rx_en or rst_n during bit 3 of 0xFF -> IDLE, busy=0, no word; the next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and constants for the oversampling UART receiver
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int OS_RATIO = 16;
    localparam int OS_MID   = 7;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per oversample tick; a zero result is clamped so the divider still runs.
    function automatic int os_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OS_RATIO);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_os_tick.sv
`default_nettype none
// ============================================================================
// uart_os_tick : 16x oversample tick generator, restartable by clear
// Revision     : 1.0
// ============================================================================
module uart_os_tick #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    import uart_pkg::*;

    localparam int DIV = os_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick is suppressed on the restart cycle so the first tick lands a full period later.
    assign tick = (cnt == LAST) && !clear;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// uart_rx_os : 16x oversampling UART receiver with valid/ready output holding
// Revision   : 1.0
// ============================================================================
module uart_rx_os #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);
    import uart_pkg::*;

    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = (STOP_BITS == 2);
    localparam logic       HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic [3:0] MID_COUNT  = 4'(OS_MID);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 tick;
    logic                 start_edge;
    logic                 start_det;
    logic                 sample;
    logic                 complete;
    logic                 par_exp;
    logic                 frame_final;
    logic [3:0]           os_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err_acc;
    logic                 frm_err_acc;
    uart_state_e          state;
    uart_state_e          state_nx;

    assign start_edge  = rx_prev && !rx_sync;
    assign start_det   = (state == ST_IDLE) && rx_en && start_edge;
    assign sample      = tick && (os_cnt == MID_COUNT);
    assign par_exp     = (PARITY == PAR_ODD) ? ~(^shift) : (^shift);
    assign frame_final = frm_err_acc | ~rx_sync;
    assign busy        = (state != ST_IDLE);

    uart_os_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_det),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        complete = 1'b0;
        if (!rx_en) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_edge) state_nx = ST_START;
                end
                ST_START: begin
                    // A high mid-sample means the edge was a glitch.
                    if (sample) state_nx = rx_sync ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample && (bit_cnt == LAST_BIT))
                        state_nx = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (sample) state_nx = ST_STOP;
                end
                ST_STOP: begin
                    // Leave at the last mid-sample so an early next start edge is not missed.
                    if (sample && (stop_cnt == LAST_STOP)) begin
                        state_nx = ST_IDLE;
                        complete = 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shift       <= '0;
            par_err_acc <= 1'b0;
            frm_err_acc <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            if (start_det) begin
                os_cnt      <= '0;
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
                par_err_acc <= 1'b0;
                frm_err_acc <= 1'b0;
            end else if (tick) begin
                os_cnt <= os_cnt + 4'd1;
            end

            if (sample) begin
                case (state)
                    ST_DATA: begin
                        shift   <= {rx_sync, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    ST_PARITY: begin
                        par_err_acc <= (rx_sync != par_exp);
                    end
                    ST_STOP: begin
                        frm_err_acc <= frame_final;
                        stop_cnt    <= stop_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output holding register: a completed word only loads when the slot is free
    // or is being emptied in the same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    frame_err  <= frame_final;
                    parity_err <= par_err_acc;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
